// File: rtl/servo_pkg.sv
// Shared types and encodings for the servo command sequencer.
// Position/select codes, FSM states and the command record.
package servo_pkg;

    localparam logic [1:0] POS_0   = 2'b00;
    localparam logic [1:0] POS_90  = 2'b01;
    localparam logic [1:0] POS_180 = 2'b10;

    localparam logic [1:0] SEL_S1  = 2'b00;
    localparam logic [1:0] SEL_S2  = 2'b01;
    localparam logic [1:0] SEL_S3  = 2'b10;
    localparam logic [1:0] SEL_ALL = 2'b11;

    localparam int CMD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [1:0] pos;
    } cmd_t;

    // The unused position code 11 is treated as 0 degrees.
    function automatic logic [1:0] norm_pos(input logic [1:0] p);
        return (p == 2'b11) ? POS_0 : p;
    endfunction

endpackage

// File: rtl/servo_sequencer_if.sv
// Command handshake bundle: valid/ready plus {sel, pos} payload.
// master = command source, slave = sequencer.
interface servo_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_sel;
    logic [1:0] cmd_pos;

    modport master (
        output cmd_valid,
        output cmd_sel,
        output cmd_pos,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_sel,
        input  cmd_pos,
        output cmd_ready
    );

endinterface

// File: rtl/servo_cmd_fifo.sv
// Synchronous command FIFO with flush and occupancy count.
// Ports: push/din, pop/dout (head, show-ahead), flush, full, empty, level.
module servo_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] lvl_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (lvl_q == LW'(DEPTH));
    assign empty   = (lvl_q == '0);
    assign level   = lvl_q;
    assign dout    = mem[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two;
    // the occupancy count separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/servo_sequencer.sv
// Servo command sequencer: queues {sel,pos} commands and applies
// them one at a time, holding a settle interval after each move.
// Ports: clk, rst_n, cmd (handshake), park, pos1..3, busy, done,
// fifo_level.
module servo_sequencer
    import servo_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 25_000_000,
    parameter int CNT_W         = 25
) (
    input  logic                          clk,
    input  logic                          rst_n,
    servo_sequencer_if.slave              cmd,
    input  logic                          park,
    output logic [1:0]                    pos1,
    output logic [1:0]                    pos2,
    output logic [1:0]                    pos3,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    cmd_t             cur_q;
    cmd_t             head;
    cmd_t             push_cmd;
    logic [CNT_W-1:0] cnt_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             settle_end;
    logic             w1;
    logic             w2;
    logic             w3;

    assign cmd.cmd_ready = !full && !park;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign push_cmd      = '{sel: cmd.cmd_sel, pos: norm_pos(cmd.cmd_pos)};
    assign settle_end    = (state_q == ST_SETTLE) && (cnt_q == '0);
    assign busy          = (state_q != ST_IDLE);

    assign w1 = (cur_q.sel == SEL_S1) || (cur_q.sel == SEL_ALL);
    assign w2 = (cur_q.sel == SEL_S2) || (cur_q.sel == SEL_ALL);
    assign w3 = (cur_q.sel == SEL_S3) || (cur_q.sel == SEL_ALL);

    servo_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (park),
        .push  (push),
        .din   (push_cmd),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (park) begin
            state_d = ST_IDLE;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
            pos1  <= POS_0;
            pos2  <= POS_0;
            pos3  <= POS_0;
        end else if (park) begin
            cnt_q <= '0;
            done  <= 1'b0;
            pos1  <= POS_0;
            pos2  <= POS_0;
            pos3  <= POS_0;
        end else begin
            done <= settle_end;
            if (pop) begin
                cur_q <= head;
            end
            if (state_q == ST_APPLY) begin
                cnt_q <= SETTLE_LOAD;
                if (w1) pos1 <= cur_q.pos;
                if (w2) pos2 <= cur_q.pos;
                if (w3) pos3 <= cur_q.pos;
            end else if (state_q == ST_SETTLE && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_servo_sequencer.sv
// Self-checking bench for servo_sequencer (SETTLE_CYCLES = 4).
// Table vectors, directed corner sequences, random vs. event model.
module tb_servo_sequencer;

    import servo_pkg::*;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       park = 1'b0;
    logic [1:0] pos1, pos2, pos3;
    logic       busy, done;
    logic [2:0] fifo_level;

    servo_sequencer_if cmd_if ();

    servo_sequencer #(
        .FIFO_DEPTH    (4),
        .SETTLE_CYCLES (S),
        .CNT_W         (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd_if.slave),
        .park       (park),
        .pos1       (pos1),
        .pos2       (pos2),
        .pos3       (pos3),
        .busy       (busy),
        .done       (done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: queued commands plus edge timestamps.
    // A command popped at edge p moves its servo at p+1, done is
    // raised by edge p+1+S and the next pop may happen at p+2+S.
    logic [3:0] mq[$];
    int         mpos[3];
    bit         mact;
    bit         mdone;
    int         mpop_e;
    int         mnext;
    int         e = 0;
    logic [3:0] mcur;

    function automatic void m_reset();
        mq.delete();
        mpos  = '{0, 0, 0};
        mact  = 0;
        mdone = 0;
        mnext = e;
    endfunction

    function automatic void m_edge(input bit v, input logic [1:0] sel,
                                   input logic [1:0] pos, input bit pk);
        bit rdy;
        rdy = (mq.size() < 4) && !pk;
        if (pk) begin
            mq.delete();
            mpos  = '{0, 0, 0};
            mact  = 0;
            mdone = 0;
            mnext = e + 1;
        end else begin
            mdone = mact && (e == mpop_e + 1 + S);
            if (mdone) begin
                mact  = 0;
                mnext = e + 1;
            end
            if (mact && e == mpop_e + 1) begin
                for (int k = 0; k < 3; k++) begin
                    if (mcur[3:2] == 2'(k) || mcur[3:2] == 2'b11)
                        mpos[k] = int'(mcur[1:0]);
                end
            end
            if (!mact && e >= mnext && mq.size() > 0) begin
                mcur   = mq.pop_front();
                mact   = 1;
                mpop_e = e;
            end
            if (v && rdy)
                mq.push_back({sel, (pos == 2'b11) ? 2'b00 : pos});
        end
        e++;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".pos1"}, 32'(pos1), 32'(mpos[0]));
        chk({tag, ".pos2"}, 32'(pos2), 32'(mpos[1]));
        chk({tag, ".pos3"}, 32'(pos3), 32'(mpos[2]));
        chk({tag, ".busy"}, 32'(busy), 32'(mact));
        chk({tag, ".done"}, 32'(done), 32'(mdone));
        chk({tag, ".level"}, 32'(fifo_level), 32'(mq.size()));
        chk({tag, ".lvl_le4"}, 32'(fifo_level <= 3'd4), 32'd1);
    endtask

    // One clock: drive at negedge, check ready, edge, check outputs.
    task automatic cycle(input bit v, input logic [1:0] sel,
                         input logic [1:0] pos, input bit pk,
                         input string tag, output bit acc);
        cmd_if.cmd_valid = v;
        cmd_if.cmd_sel   = sel;
        cmd_if.cmd_pos   = pos;
        park             = pk;
        #1;
        chk({tag, ".ready"}, 32'(cmd_if.cmd_ready),
            32'((mq.size() < 4) && !pk));
        acc = v && cmd_if.cmd_ready;
        @(posedge clk);
        m_edge(v, sel, pos, pk);
        @(negedge clk);
        check_outs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        bit a;
        for (int i = 0; i < n; i++) cycle(0, 2'b00, 2'b00, 0, tag, a);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((mact || mq.size() != 0) && guard < 200) begin
            idle(1, tag);
            guard++;
        end
        chk({tag, ".drain_timeout"}, 32'(guard < 200), 32'd1);
        idle(1, tag);
    endtask

    typedef struct {
        bit         v;
        logic [1:0] sel;
        logic [1:0] pos;
        logic [1:0] e1, e2, e3;
        bit         eb;
        bit         ed;
        int         el;
    } vec_t;

    vec_t tbl[16];

    typedef struct {
        logic [1:0] sel;
        logic [1:0] pos;
    } src_t;

    initial begin
        bit         a;
        bit         have;
        bit         saw_full;
        bit         pk;
        logic [1:0] hs, hp;
        src_t       pend[$];
        int         guard;

        cmd_if.cmd_valid = 0;
        cmd_if.cmd_sel   = 0;
        cmd_if.cmd_pos   = 0;

        // Single command to servo2, then pos=11 normalised on servo1.
        tbl[0]  = '{1, 2'b01, 2'b10, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0};
        tbl[2]  = '{0, 2'b00, 2'b00, 0, 2, 0, 1, 0, 0};
        tbl[3]  = '{0, 2'b00, 2'b00, 0, 2, 0, 1, 0, 0};
        tbl[4]  = '{0, 2'b00, 2'b00, 0, 2, 0, 1, 0, 0};
        tbl[5]  = '{0, 2'b00, 2'b00, 0, 2, 0, 1, 0, 0};
        tbl[6]  = '{0, 2'b00, 2'b00, 0, 2, 0, 0, 1, 0};
        tbl[7]  = '{0, 2'b00, 2'b00, 0, 2, 0, 0, 0, 0};
        tbl[8]  = '{1, 2'b00, 2'b11, 0, 2, 0, 0, 0, 1};
        tbl[9]  = '{0, 2'b00, 2'b00, 0, 2, 0, 1, 0, 0};
        tbl[10] = '{0, 2'b00, 2'b00, 0, 2, 0, 1, 0, 0};
        tbl[11] = '{0, 2'b00, 2'b00, 0, 2, 0, 1, 0, 0};
        tbl[12] = '{0, 2'b00, 2'b00, 0, 2, 0, 1, 0, 0};
        tbl[13] = '{0, 2'b00, 2'b00, 0, 2, 0, 1, 0, 0};
        tbl[14] = '{0, 2'b00, 2'b00, 0, 2, 0, 0, 1, 0};
        tbl[15] = '{0, 2'b00, 2'b00, 0, 2, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        #1;
        chk("rst.pos1", 32'(pos1), 0);
        chk("rst.pos2", 32'(pos2), 0);
        chk("rst.pos3", 32'(pos3), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.level", 32'(fifo_level), 0);
        chk("rst.ready", 32'(cmd_if.cmd_ready), 1);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].v, tbl[i].sel, tbl[i].pos, 0, "tbl", a);
            chk($sformatf("tbl%0d.pos1", i), 32'(pos1), 32'(tbl[i].e1));
            chk($sformatf("tbl%0d.pos2", i), 32'(pos2), 32'(tbl[i].e2));
            chk($sformatf("tbl%0d.pos3", i), 32'(pos3), 32'(tbl[i].e3));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d.lvl", i), 32'(fifo_level), 32'(tbl[i].el));
        end

        // Burst of six with a source that holds until accepted.
        pend.push_back('{2'b00, 2'b01});
        pend.push_back('{2'b01, 2'b10});
        pend.push_back('{2'b10, 2'b01});
        pend.push_back('{2'b11, 2'b10});
        pend.push_back('{2'b00, 2'b10});
        pend.push_back('{2'b01, 2'b10});
        saw_full = 0;
        guard = 0;
        while (pend.size() != 0 && guard < 100) begin
            cycle(1, pend[0].sel, pend[0].pos, 0, "burst", a);
            if (fifo_level == 3'd4) saw_full = 1;
            if (a) void'(pend.pop_front());
            guard++;
        end
        chk("burst.timeout", 32'(guard < 100), 1);
        chk("burst.saw_full", 32'(saw_full), 1);
        drain("burst");
        chk("burst.fin1", 32'(pos1), 32'(POS_180));
        chk("burst.fin2", 32'(pos2), 32'(POS_180));
        chk("burst.fin3", 32'(pos3), 32'(POS_180));

        // Park mid-settle with two queued; offered command is dropped.
        cycle(1, 2'b00, 2'b01, 0, "park", a);
        cycle(1, 2'b01, 2'b01, 0, "park", a);
        cycle(1, 2'b10, 2'b01, 0, "park", a);
        cycle(0, 2'b00, 2'b00, 0, "park", a);
        cycle(0, 2'b00, 2'b00, 0, "park", a);
        chk("park.pre_busy", 32'(busy), 1);
        chk("park.pre_lvl", 32'(fifo_level), 2);
        chk("park.pre_pos1", 32'(pos1), 32'(POS_90));
        cycle(1, 2'b11, 2'b10, 1, "park", a);
        chk("park.acc", 32'(a), 0);
        chk("park.pos1", 32'(pos1), 0);
        chk("park.pos2", 32'(pos2), 0);
        chk("park.pos3", 32'(pos3), 0);
        chk("park.lvl", 32'(fifo_level), 0);
        chk("park.busy", 32'(busy), 0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 2'b00, 2'b00, 0, "park_after", a);
            chk("park.no_done", 32'(done), 0);
        end

        // Async reset pulse between edges during settle.
        cycle(1, 2'b11, 2'b01, 0, "arst", a);
        idle(4, "arst");
        chk("arst.pre_pos3", 32'(pos3), 32'(POS_90));
        #2 rst_n = 1'b0;
        #1;
        chk("arst.pos1", 32'(pos1), 0);
        chk("arst.pos2", 32'(pos2), 0);
        chk("arst.pos3", 32'(pos3), 0);
        chk("arst.busy", 32'(busy), 0);
        chk("arst.lvl", 32'(fifo_level), 0);
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        cycle(1, 2'b10, 2'b10, 0, "resume", a);
        drain("resume");
        chk("resume.pos3", 32'(pos3), 32'(POS_180));

        // Random traffic with a holding source and occasional park.
        have = 0;
        hs = 0;
        hp = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!have && $urandom_range(9) < 6) begin
                have = 1;
                hs = 2'($urandom_range(3));
                hp = 2'($urandom_range(3));
            end
            pk = ($urandom_range(39) == 0);
            cycle(have, hs, hp, pk, "rand", a);
            if (a || pk) have = 0;
        end
        drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
